// File: rtl/sram_pkg.sv
// Shared SRAM definitions: arbiter state encoding and the sram_1c bus widths.
package sram_pkg;

  localparam int SRAM_AW = 17;
  localparam int SRAM_DW = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_GAP  = 2'd2
  } arb_state_t;

endpackage

// File: rtl/sram_arbiter.sv
// Two-master round-robin Wishbone arbiter in front of the sram_1c controller.
// One transfer per grant, registered slave request, one idle GAP cycle between
// transfers, and a watchdog that aborts a transfer the slave never acknowledges.
module sram_arbiter
  import sram_pkg::*;
#(
  parameter int TIMEOUT = 1023,
  parameter int TW      = 10
) (
  input  logic               wb_clk_i,
  input  logic               rst_i,
  input  logic               m0_cyc_i,
  input  logic               m0_we_i,
  input  logic [SRAM_AW-1:0] m0_addr_i,
  input  logic [SRAM_DW-1:0] m0_datw_i,
  output logic               m0_ack_o,
  output logic               m0_err_o,
  output logic [SRAM_DW-1:0] m0_datr_o,
  input  logic               m1_cyc_i,
  input  logic               m1_we_i,
  input  logic [SRAM_AW-1:0] m1_addr_i,
  input  logic [SRAM_DW-1:0] m1_datw_i,
  output logic               m1_ack_o,
  output logic               m1_err_o,
  output logic [SRAM_DW-1:0] m1_datr_o,
  output logic               s_cyc_o,
  output logic               s_we_o,
  output logic [SRAM_AW-1:0] s_addr_o,
  output logic [SRAM_DW-1:0] s_datw_o,
  input  logic               s_ack_i,
  input  logic [SRAM_DW-1:0] s_datr_i,
  output logic [1:0]         gnt_o
);

  localparam logic [TW-1:0] TIMEOUT_CNT = TW'(TIMEOUT);

  arb_state_t         state_q, state_d;
  logic               ptr_q, ptr_d;
  logic [TW-1:0]      cnt_q, cnt_d;
  logic               aborted_q, aborted_d;
  logic               s_cyc_q, s_cyc_d;
  logic               s_we_q, s_we_d;
  logic [SRAM_AW-1:0] s_addr_q, s_addr_d;
  logic [SRAM_DW-1:0] s_datw_q, s_datw_d;
  logic [1:0]         gnt_q, gnt_d;
  logic [1:0]         ack_q, ack_d;
  logic [1:0]         err_q, err_d;
  logic [SRAM_DW-1:0] datr0_q, datr0_d;
  logic [SRAM_DW-1:0] datr1_q, datr1_d;
  logic               pick_m1;
  logic               owner_m1;
  logic               owner_live;

  // Next-state logic: grant in IDLE, wait for ack/timeout in BUSY, single GAP cycle.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    aborted_d = aborted_q;
    s_cyc_d   = s_cyc_q;
    s_we_d    = s_we_q;
    s_addr_d  = s_addr_q;
    s_datw_d  = s_datw_q;
    gnt_d     = gnt_q;
    ack_d     = 2'b00;
    err_d     = 2'b00;
    datr0_d   = datr0_q;
    datr1_d   = datr1_q;

    pick_m1    = m1_cyc_i && (!m0_cyc_i || ptr_q);
    owner_m1   = gnt_q[1];
    owner_live = !aborted_q && (owner_m1 ? m1_cyc_i : m0_cyc_i);

    case (state_q)
      ST_IDLE: begin
        if (m0_cyc_i || m1_cyc_i) begin
          state_d   = ST_BUSY;
          s_cyc_d   = 1'b1;
          cnt_d     = '0;
          aborted_d = 1'b0;
          gnt_d     = pick_m1 ? 2'b10 : 2'b01;
          s_we_d    = pick_m1 ? m1_we_i : m0_we_i;
          s_addr_d  = pick_m1 ? m1_addr_i : m0_addr_i;
          s_datw_d  = pick_m1 ? m1_datw_i : m0_datw_i;
        end
      end
      ST_BUSY: begin
        aborted_d = !owner_live;
        if (s_ack_i || (cnt_q == TIMEOUT_CNT)) begin
          if (owner_live) begin
            if (s_ack_i) begin
              ack_d = gnt_q;
              if (owner_m1) datr1_d = s_datr_i;
              else          datr0_d = s_datr_i;
            end else begin
              err_d = gnt_q;
            end
          end
          s_cyc_d = 1'b0;
          gnt_d   = 2'b00;
          ptr_d   = !owner_m1;
          state_d = ST_GAP;
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      end
      ST_GAP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge wb_clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      ptr_q     <= 1'b0;
      cnt_q     <= '0;
      aborted_q <= 1'b0;
      s_cyc_q   <= 1'b0;
      s_we_q    <= 1'b0;
      s_addr_q  <= '0;
      s_datw_q  <= '0;
      gnt_q     <= 2'b00;
      ack_q     <= 2'b00;
      err_q     <= 2'b00;
      datr0_q   <= '0;
      datr1_q   <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      aborted_q <= aborted_d;
      s_cyc_q   <= s_cyc_d;
      s_we_q    <= s_we_d;
      s_addr_q  <= s_addr_d;
      s_datw_q  <= s_datw_d;
      gnt_q     <= gnt_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      datr0_q   <= datr0_d;
      datr1_q   <= datr1_d;
    end
  end

  assign s_cyc_o   = s_cyc_q;
  assign s_we_o    = s_we_q;
  assign s_addr_o  = s_addr_q;
  assign s_datw_o  = s_datw_q;
  assign gnt_o     = gnt_q;
  assign m0_ack_o  = ack_q[0];
  assign m1_ack_o  = ack_q[1];
  assign m0_err_o  = err_q[0];
  assign m1_err_o  = err_q[1];
  assign m0_datr_o = datr0_q;
  assign m1_datr_o = datr1_q;

endmodule
